// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and widths for the lap capture/review stage
package stopwatch_pkg;

    localparam int LAP_IDX_W = 4;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [9:0] ms;
    } lap_time_t;

    typedef enum logic {
        LIVE   = 1'b0,
        REVIEW = 1'b1
    } lap_state_e;

endpackage

// File: rtl/lap_record_ctrl_store.sv
// lap_record_ctrl_store: LAP_DEPTH x 34-bit lap register file, one write port, combinational read
import stopwatch_pkg::*;

module lap_record_ctrl_store #(
    parameter int LAP_DEPTH = 9
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LAP_IDX_W-1:0] waddr,
    input  lap_time_t            wdata,
    input  logic [LAP_IDX_W-1:0] raddr,
    output lap_time_t            rdata
);

    lap_time_t mem [LAP_DEPTH];

    // slots are never cleared; a clear only rewinds the lap count
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_record_ctrl.sv
// lap_record_ctrl: lap snapshot and review mux ahead of the display driver (optional LAP_TIMEOUT_EN review auto-exit)
import stopwatch_pkg::*;

module lap_record_ctrl #(
    parameter int LAP_DEPTH  = 9,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_1ms,
    input  logic                 run,
    input  logic [7:0]           live_hours,
    input  logic [7:0]           live_minutes,
    input  logic [7:0]           live_seconds,
    input  logic [9:0]           live_millisec,
    input  logic                 lap_pulse,
    input  logic                 view_pulse,
    input  logic                 clear_pulse,
    output logic [7:0]           hours,
    output logic [7:0]           minutes,
    output logic [7:0]           seconds,
    output logic [9:0]           millisec,
    output logic                 lap_view,
    output logic [LAP_IDX_W-1:0] lap_num,
    output logic                 blink_en,
    output logic                 lap_full
);

    localparam logic [LAP_IDX_W-1:0] DEPTH = LAP_IDX_W'(LAP_DEPTH);

    lap_state_e           state, state_nx;
    logic [LAP_IDX_W-1:0] count, rd_idx;
    logic                 clr, lap, view, we, view_last, any_btn, timeout;
    lap_time_t            live_t, rdata;

    assign clr       = clear_pulse;
    assign lap       = lap_pulse & ~clear_pulse;
    assign view      = view_pulse & ~clear_pulse & ~lap_pulse;
    assign any_btn   = lap_pulse | view_pulse | clear_pulse;
    assign we        = lap & run & (count != DEPTH);
    assign view_last = rd_idx == count - 1'b1;
    assign live_t    = {live_hours, live_minutes, live_seconds, live_millisec};

    lap_record_ctrl_store #(.LAP_DEPTH(LAP_DEPTH)) u_store (
        .clk  (clk),
        .we   (we),
        .waddr(count),
        .wdata(live_t),
        .raddr(rd_idx),
        .rdata(rdata)
    );

`ifdef LAP_TIMEOUT_EN
    localparam logic [12:0] IDLE_LAST = 13'(TIMEOUT_MS - 1);
    logic [12:0] idle;

    assign timeout = (state == REVIEW) & tick_1ms & ~any_btn & (idle == IDLE_LAST);

    // idle time in REVIEW; any button press or leaving REVIEW restarts it
    always_ff @(posedge clk) begin
        if (!rst_n) idle <= '0;
        else idle <= (state != REVIEW || any_btn || timeout) ? '0 : idle + 13'(tick_1ms);
    end
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {tick_1ms, TIMEOUT_MS != 0};
    assign timeout    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LIVE;
        else state <= state_nx;
    end

    // next state: enter review on view with laps stored; leave on clear, timeout or view past the last lap
    always_comb begin
        state_nx = (state == LIVE) ? ((view && count != '0) ? REVIEW : LIVE)
                                   : ((clr || timeout || (view && view_last)) ? LIVE : REVIEW);
    end

    // lap count and review index; rd_idx sits at 0 whenever not reviewing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_idx <= '0;
        end else begin
            if (clr && state == LIVE && !run) count <= '0;
            else if (we) count <= count + 1'b1;
            rd_idx <= (state_nx != REVIEW) ? '0 : (state == REVIEW && view) ? rd_idx + 1'b1 : rd_idx;
        end
    end

    // registered time mux toward the display driver
    always_ff @(posedge clk) begin
        if (!rst_n) {hours, minutes, seconds, millisec} <= '0;
        else {hours, minutes, seconds, millisec} <= (state == REVIEW) ? rdata : live_t;
    end

    // status outputs derived from state and counters
    always_comb begin
        lap_full = count == DEPTH;
        lap_view = state == REVIEW;
        lap_num  = (state == REVIEW) ? rd_idx + 1'b1 : count;
        blink_en = lap_full & (state == LIVE);
    end

endmodule
